e3_div_9: RTL

- Sequential divider, the inverse of the excess-3 ×9 multiplier.
- Accepts a two-digit excess-3 number (tens, units; 00..99).
- Returns the quotient by 9 as two excess-3 digits and the remainder as one excess-3 digit.
- Division is by repeated subtraction of 9, one subtraction per clock, entirely in excess-3 digit arithmetic (no binary conversion).
- Valid/ready handshake on both input and output.

---
 rtl/e3_div_9.sv | 122 ++++++++++++
 1 files changed

// File: rtl/e3_div_9.sv
// Excess-3 two-digit divide-by-9 by repeated digit-wise subtraction, one step per clock.
// Optional operand code check enabled by defining E3_DIV9_CHECK_EN.
module e3_div_9 (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] e3_d,
  input  logic [3:0] e3_u,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] e3_q_d,
  output logic [3:0] e3_q_u,
  output logic [3:0] e3_rem,
  output logic       err
);

  localparam logic [3:0] E3_ZERO = 4'b0011;
  localparam logic [3:0] E3_NINE = 4'b1100;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] acc_d_q, acc_d_d, acc_u_q, acc_u_d;
  logic [3:0] q_d_q, q_d_d, q_u_q, q_u_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       ge9, accept, bad, step_ok;

  assign ge9     = (acc_d_q != E3_ZERO) || (acc_u_q == E3_NINE);
  assign accept  = in_valid && (state_q == IDLE);
  // Step counter caps CALC at 16 edges even for garbage codes.
  assign step_ok = ge9 && (cnt_q != 4'hF);

`ifdef E3_DIV9_CHECK_EN
  assign bad = (e3_d < E3_ZERO) || (e3_d > E3_NINE) ||
               (e3_u < E3_ZERO) || (e3_u > E3_NINE);
`else
  assign bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      acc_d_q <= 4'b0;
      acc_u_q <= 4'b0;
      q_d_q   <= E3_ZERO;
      q_u_q   <= E3_ZERO;
      rem_q   <= E3_ZERO;
      cnt_q   <= 4'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_d_q <= acc_d_d;
      acc_u_q <= acc_u_d;
      q_d_q   <= q_d_d;
      q_u_q   <= q_u_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = bad ? DONE : CALC;
      CALC:    if (!step_ok) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d_d = acc_d_q;
    acc_u_d = acc_u_q;
    q_d_d   = q_d_q;
    q_u_d   = q_u_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (state_q == IDLE && accept) begin
      acc_d_d = e3_d;
      acc_u_d = e3_u;
      q_d_d   = E3_ZERO;
      q_u_d   = E3_ZERO;
      cnt_d   = 4'b0;
      err_d   = bad;
      if (bad) rem_d = E3_ZERO;
    end else if (state_q == CALC) begin
      if (step_ok) begin
        // x9 -> x0 leaves tens alone; otherwise borrow a ten and add one unit (-10+1).
        if (acc_u_q == E3_NINE) begin
          acc_u_d = E3_ZERO;
        end else begin
          acc_u_d = acc_u_q + 4'd1;
          acc_d_d = acc_d_q - 4'd1;
        end
        if (q_u_q == E3_NINE) begin
          q_u_d = E3_ZERO;
          q_d_d = q_d_q + 4'd1;
        end else begin
          q_u_d = q_u_q + 4'd1;
        end
        cnt_d = cnt_q + 4'd1;
      end else begin
        rem_d = acc_u_q;
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    e3_q_d    = q_d_q;
    e3_q_u    = q_u_q;
    e3_rem    = rem_q;
    err       = err_q;
  end

endmodule
